mc_port_arbiter: RTL and testbench

Two-port arbiter between the cache-side memory command interfaces (data cache on port 1, second client on port 2) and the single DDR2 memory-controller command interface. It accepts one outstanding command at a time and chooses between ports round-robin. It forwards the address, write data and read/write flag to the MC, waits for completion, and returns a one-cycle ready pulse with read data to the owning port. A response timeout sets a sticky error for the checker bench.

---
 rtl/mc_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mc_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_port_arbiter.sv
// mc_port_arbiter: two-port round-robin arbiter in front of the DDR2
// memory-controller command interface. Port 1 is the data cache, port 2 the
// second client. One command is outstanding at a time; completion is
// returned to the owning port as a one-cycle ready pulse with read data.
// A WAIT-state timeout forces completion and sets a sticky error flag.
module mc_port_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // port 1 (data cache)
  input  logic [DATA_W-1:0] mem_data_wr1,
  input  logic [ADDR_W-1:0] mem_data_addr1,
  input  logic              mem_rw_data1,
  input  logic              mem_valid_data1,
  output logic [DATA_W-1:0] mem_data_rd1,
  output logic              mem_ready_data1,
  // port 2 (second client)
  input  logic [DATA_W-1:0] mem_data_wr2,
  input  logic [ADDR_W-1:0] mem_data_addr2,
  input  logic              mem_rw_data2,
  input  logic              mem_valid_data2,
  output logic [DATA_W-1:0] mem_data_rd2,
  output logic              mem_ready_data2,
  // memory-controller command interface
  output logic              mc_cmd_valid,
  input  logic              mc_cmd_ack,
  output logic              mc_rw,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_wr_data,
  input  logic              mc_rsp_valid,
  input  logic [DATA_W-1:0] mc_rd_data,
  // status
  output logic              grant,
  output logic              error
);

  // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;

  logic              req_any;
  logic              pick;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              timeout_hit;
  logic              wait_done;
  logic [DATA_W-1:0] rsp_data;

  // Arbitration choice and command mux, plus WAIT completion decode.
  always_comb begin
    req_any     = mem_valid_data1 | mem_valid_data2;
    // With both ports requesting, the port that did not own the last
    // command wins; otherwise the lone requester wins.
    pick        = (mem_valid_data1 & mem_valid_data2) ? ~last_grant : mem_valid_data2;
    sel_rw      = pick ? mem_rw_data2   : mem_rw_data1;
    sel_addr    = pick ? mem_data_addr2 : mem_data_addr1;
    sel_wdata   = pick ? mem_data_wr2   : mem_data_wr1;
    timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
    // A real response beats a timeout landing in the same cycle.
    wait_done   = mc_rsp_valid | timeout_hit;
    rsp_data    = mc_rsp_valid ? mc_rd_data : '0;
  end

  // Command FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      cnt             <= '0;
      mem_data_rd1    <= '0;
      mem_data_rd2    <= '0;
      mem_ready_data1 <= 1'b0;
      mem_ready_data2 <= 1'b0;
      mc_cmd_valid    <= 1'b0;
      mc_rw           <= 1'b0;
      mc_addr         <= '0;
      mc_wr_data      <= '0;
      grant           <= 1'b0;
      error           <= 1'b0;
    end else begin
      // Ready is a single-cycle pulse; it is only raised on entry to RESP.
      mem_ready_data1 <= 1'b0;
      mem_ready_data2 <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            grant        <= pick;
            mc_rw        <= sel_rw;
            mc_addr      <= sel_addr;
            mc_wr_data   <= sel_wdata;
            mc_cmd_valid <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (mc_cmd_ack) begin
            mc_cmd_valid <= 1'b0;
            cnt          <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (wait_done) begin
            state <= RESP;
            if (!mc_rsp_valid) begin
              error <= 1'b1;
            end
            if (grant) begin
              mem_ready_data2 <= 1'b1;
              if (!mc_rw) begin
                mem_data_rd2 <= rsp_data;
              end
            end else begin
              mem_ready_data1 <= 1'b1;
              if (!mc_rw) begin
                mem_data_rd1 <= rsp_data;
              end
            end
          end
        end
        RESP: begin
          // The IDLE cycle that follows keeps a still-high old valid from
          // being accepted a second time.
          last_grant <= grant;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Testbench for mc_port_arbiter: directed command scenarios, a timeline
// model of each command's life (grant, issue window, completion cycle) and a
// per-cycle compare of every DUT output against that model.
module tb_mc_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 256;
  localparam int TO = 4;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            da;     // ISSUE cycles before ack (0 = ack in first ISSUE cycle)
    int            dr;     // WAIT cycles before rsp (>= TO means never)
    bit            noise;  // stray rsp in ISSUE and stray ack in WAIT
    bit            drop;   // port drops valid once its command is granted
  } cmd_t;

  logic          clk, rst;
  logic [DW-1:0] mem_data_wr1, mem_data_wr2, mem_data_rd1, mem_data_rd2;
  logic [AW-1:0] mem_data_addr1, mem_data_addr2;
  logic          mem_rw_data1, mem_rw_data2, mem_valid_data1, mem_valid_data2;
  logic          mem_ready_data1, mem_ready_data2;
  logic          mc_cmd_valid, mc_cmd_ack, mc_rw, mc_rsp_valid;
  logic [AW-1:0] mc_addr;
  logic [DW-1:0] mc_wr_data, mc_rd_data;
  logic          grant, error;

  mc_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_data_wr1(mem_data_wr1), .mem_data_addr1(mem_data_addr1),
    .mem_rw_data1(mem_rw_data1), .mem_valid_data1(mem_valid_data1),
    .mem_data_rd1(mem_data_rd1), .mem_ready_data1(mem_ready_data1),
    .mem_data_wr2(mem_data_wr2), .mem_data_addr2(mem_data_addr2),
    .mem_rw_data2(mem_rw_data2), .mem_valid_data2(mem_valid_data2),
    .mem_data_rd2(mem_data_rd2), .mem_ready_data2(mem_ready_data2),
    .mc_cmd_valid(mc_cmd_valid), .mc_cmd_ack(mc_cmd_ack), .mc_rw(mc_rw),
    .mc_addr(mc_addr), .mc_wr_data(mc_wr_data), .mc_rsp_valid(mc_rsp_valid),
    .mc_rd_data(mc_rd_data), .grant(grant), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int tcyc  = 0;

  logic [DW-1:0] JUNK = {8{32'hDEADBEEF}};
  cmd_t q1[$], q2[$];

  // ---------------- model ----------------
  int            cyc = 0;
  bit            m_busy, m_owner, m_to, m_last;
  cmd_t          m_cmd;
  int            m_issue, m_ack, m_rsp, m_resp, m_free;
  logic          m_grant, m_rw, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd1, m_rd2;
  logic          e_cmdv, e_rdy1, e_rdy2;

  function automatic logic [DW-1:0] pat(input logic [31:0] base);
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = base + 32'(8 * i);
    return r;
  endfunction

  function automatic cmd_t mk(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [DW-1:0] rd, input int da, input int dr,
                              input bit noise, input bit drop);
    cmd_t c;
    c.rw = rw; c.addr = a; c.wdata = wd; c.rdata = rd;
    c.da = da; c.dr = dr; c.noise = noise; c.drop = drop;
    return c;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_to = 0; m_last = 1;
    m_issue = -1; m_ack = -1; m_rsp = -1; m_resp = -1; m_free = cyc;
    m_grant = 0; m_rw = 0; m_err = 0; m_addr = '0; m_wd = '0; m_rd1 = '0; m_rd2 = '0;
    e_cmdv = 0; e_rdy1 = 0; e_rdy2 = 0;
  endtask

  // Advance one cycle: retire a command whose completion cycle has come,
  // then accept a new one if the arbiter was idle in the previous cycle.
  task automatic model_step();
    bit win;
    int w;
    logic [DW-1:0] d;
    cyc++;
    e_rdy1 = 0; e_rdy2 = 0;
    if (m_busy && cyc == m_resp) begin
      m_busy = 0;
      if (m_owner) e_rdy2 = 1; else e_rdy1 = 1;
      if (!m_cmd.rw) begin
        d = m_to ? '0 : m_cmd.rdata;
        if (m_owner) m_rd2 = d; else m_rd1 = d;
      end
      if (m_to) m_err = 1;
      m_last = m_owner;
      m_free = cyc + 1;
    end
    if (!m_busy && cyc - 1 >= m_free && (mem_valid_data1 || mem_valid_data2)) begin
      win = (mem_valid_data1 && mem_valid_data2) ? !m_last : mem_valid_data2;
      if (win) begin m_cmd = q2[0]; void'(q2.pop_front()); end
      else     begin m_cmd = q1[0]; void'(q1.pop_front()); end
      m_owner = win; m_grant = win;
      m_rw = m_cmd.rw; m_addr = m_cmd.addr; m_wd = m_cmd.wdata;
      m_issue = cyc;
      m_ack = cyc + m_cmd.da;
      w = m_ack + 1;
      if (m_cmd.dr <= TO - 1) begin
        m_to = 0; m_rsp = w + m_cmd.dr; m_resp = m_rsp + 1;
      end else begin
        m_to = 1; m_rsp = -1; m_resp = w + TO;
      end
      m_busy = 1;
    end
    e_cmdv = m_busy && cyc >= m_issue && cyc <= m_ack;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // ---------------- stimulus drivers ----------------
  task automatic present(input bit p, output logic v, output cmd_t c);
    cmd_t idle_c;
    idle_c = mk(1'b0, '0, '0, '0, 0, 0, 0, 0);
    if (p ? (q2.size() > 0) : (q1.size() > 0)) begin
      c = p ? q2[0] : q1[0]; v = 1;
    end else if (m_busy && m_owner == p && !m_cmd.drop) begin
      c = m_cmd; v = 1;
    end else if (m_busy && m_owner == p) begin
      c = mk(~m_cmd.rw, '1, ~m_cmd.wdata, '0, 0, 0, 0, 0); v = 0;
    end else begin
      c = idle_c; v = 0;
    end
  endtask

  initial begin
    cmd_t c;
    logic v, ack, rsp_real, rsp;
    mem_valid_data1 = 0; mem_rw_data1 = 0; mem_data_addr1 = '0; mem_data_wr1 = '0;
    mem_valid_data2 = 0; mem_rw_data2 = 0; mem_data_addr2 = '0; mem_data_wr2 = '0;
    mc_cmd_ack = 0; mc_rsp_valid = 0; mc_rd_data = '0;
    forever begin
      @(negedge clk);
      present(1'b0, v, c);
      mem_valid_data1 = v; mem_rw_data1 = c.rw; mem_data_addr1 = c.addr; mem_data_wr1 = c.wdata;
      present(1'b1, v, c);
      mem_valid_data2 = v; mem_rw_data2 = c.rw; mem_data_addr2 = c.addr; mem_data_wr2 = c.wdata;
      ack      = m_busy && cyc == m_ack;
      ack      = ack || (m_busy && m_cmd.noise && cyc > m_ack);
      rsp_real = m_busy && !m_to && cyc == m_rsp;
      rsp      = rsp_real || (m_busy && m_cmd.noise && cyc >= m_issue && cyc <= m_ack);
      mc_cmd_ack   = ack;
      mc_rsp_valid = rsp;
      mc_rd_data   = rsp_real ? m_cmd.rdata : JUNK;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic expire(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired at cycle %0d", nm, tcyc);
  endtask

  // Every cycle, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("mc_cmd_valid", mc_cmd_valid, e_cmdv);
      chk("mc_rw", mc_rw, m_rw);
      chk("mc_addr", mc_addr, m_addr);
      chk("mc_wr_data", mc_wr_data, m_wd);
      chk("grant", grant, m_grant);
      chk("mem_ready_data1", mem_ready_data1, e_rdy1);
      chk("mem_ready_data2", mem_ready_data2, e_rdy2);
      chk("mem_data_rd1", mem_data_rd1, m_rd1);
      chk("mem_data_rd2", mem_data_rd2, m_rd2);
      chk("error", error, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  // which: 0 mc_cmd_valid, 1 ready1, 2 ready2
  task automatic wait_for(input int which, input int budget, output int t, output bit ok);
    ok = 0; t = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if ((which == 0 && mc_cmd_valid) || (which == 1 && mem_ready_data1) ||
          (which == 2 && mem_ready_data2)) begin
        ok = 1; t = tcyc;
        break;
      end
    end
    if (!ok) expire($sformatf("wait_for_%0d", which));
  endtask

  task automatic settle(input int budget, output int n_cmd, output int n_r1, output int n_r2);
    logic prev;
    bit done;
    n_cmd = 0; n_r1 = 0; n_r2 = 0; done = 0;
    prev = mc_cmd_valid;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (mc_cmd_valid && !prev) n_cmd++;
      prev = mc_cmd_valid;
      if (mem_ready_data1) n_r1++;
      if (mem_ready_data2) n_r2++;
      if (!m_busy && q1.size() == 0 && q2.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) expire("settle");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t0, t1, nc, r1, r2, n;
    bit ok;
    logic gseq [8];
    logic exp_g [8];
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_valid", mc_cmd_valid, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_ready1", mem_ready_data1, 1'b0);
    chk("rst_rd2", mem_data_rd2, '0);
    rst = 1'b1;
    tick();

    // Port 1 write, ack in first ISSUE cycle, rsp on third WAIT cycle.
    q1.push_back(mk(1'b1, 28'h0001000, pat(32'h800020C0), JUNK, 0, 2, 0, 0));
    wait_for(0, 20, t0, ok);
    if (ok) begin
      chk("s1_mc_rw", mc_rw, 1'b1);
      chk("s1_mc_addr", mc_addr, 28'h0001000);
      chk("s1_mc_wr_data", mc_wr_data,
          256'h800020F8_800020F0_800020E8_800020E0_800020D8_800020D0_800020C8_800020C0);
    end
    wait_for(1, 20, t1, ok);
    if (ok) begin
      chk("s1_latency", t1 - t0, 4);
      chk("s1_rd1_untouched", mem_data_rd1, '0);
      chk("s1_ready2_quiet", mem_ready_data2, 1'b0);
    end
    settle(50, nc, r1, r2);

    // Port 2 read, valid dropped while the command is in flight.
    q2.push_back(mk(1'b0, 28'h0001008, JUNK, pat(32'hFF0020C0), 1, 0, 0, 1));
    wait_for(2, 30, t1, ok);
    if (ok) chk("s2_rd2", mem_data_rd2,
                256'hFF0020F8_FF0020F0_FF0020E8_FF0020E0_FF0020D8_FF0020D0_FF0020C8_FF0020C0);
    settle(50, nc, r1, r2);
    chk("s2_one_ready", r2, 0);

    // Both ports continuously valid: grants alternate starting with port 1.
    q1.push_back(mk(1'b1, 28'h0000100, pat(32'h01000000), JUNK, 0, 0, 0, 0));
    q1.push_back(mk(1'b0, 28'h0000104, JUNK, pat(32'h11000000), 1, 1, 1, 0));
    q1.push_back(mk(1'b1, 28'h0000108, pat(32'h21000000), JUNK, 2, 3, 0, 0));
    q1.push_back(mk(1'b0, 28'h000010C, JUNK, pat(32'h31000000), 0, 0, 0, 0));
    q2.push_back(mk(1'b0, 28'h0000200, JUNK, pat(32'h02000000), 0, 2, 0, 0));
    q2.push_back(mk(1'b1, 28'h0000204, pat(32'h12000000), JUNK, 1, 0, 1, 0));
    q2.push_back(mk(1'b0, 28'h0000208, JUNK, pat(32'h22000000), 3, 1, 0, 0));
    q2.push_back(mk(1'b1, 28'h000020C, pat(32'h32000000), JUNK, 0, 0, 0, 0));
    n = 0;
    for (int k = 0; k < 300 && n < 8; k++) begin
      tick();
      if (mem_ready_data1 || mem_ready_data2) begin
        gseq[n] = grant;
        n++;
      end
    end
    if (n < 8) expire("s3_grants");
    for (int i = 0; i < n; i++) chk($sformatf("s3_grant_%0d", i), gseq[i], exp_g[i]);
    settle(50, nc, r1, r2);

    // Cache-dummy write then read of the same line; MC echoes the data.
    q1.push_back(mk(1'b1, 28'h3001038, pat(32'h12345670), JUNK, 0, 1, 0, 0));
    q1.push_back(mk(1'b0, 28'h3001038, JUNK, pat(32'h12345670), 1, 0, 0, 0));
    settle(80, nc, r1, r2);
    chk("s4_cmd_count", nc, 2);
    chk("s4_ready1_count", r1, 2);
    chk("s4_ready2_count", r2, 0);
    chk("s4_echo", mem_data_rd1,
        256'h123456A8_123456A0_12345698_12345690_12345688_12345680_12345678_12345670);

    // Timeout: no response at all, ack two cycles into ISSUE.
    q1.push_back(mk(1'b0, 28'h0002000, JUNK, JUNK, 2, 99, 0, 0));
    wait_for(0, 20, t0, ok);
    wait_for(1, 30, t1, ok);
    if (ok) begin
      chk("s5_to_latency", t1 - t0, 7);
      chk("s5_error", error, 1'b1);
      chk("s5_rd1_zero", mem_data_rd1, '0);
    end
    settle(50, nc, r1, r2);
    // Response and timeout in the same cycle: normal data, error stays set.
    q2.push_back(mk(1'b0, 28'h0002008, JUNK, pat(32'h5A5A0000), 0, 3, 0, 0));
    wait_for(2, 30, t1, ok);
    if (ok) begin
      chk("s5_rd2", mem_data_rd2,
          256'h5A5A0038_5A5A0030_5A5A0028_5A5A0020_5A5A0018_5A5A0010_5A5A0008_5A5A0000);
      chk("s5_error_sticky", error, 1'b1);
    end
    settle(50, nc, r1, r2);

    // Asynchronous reset while a port 2 command sits in ISSUE.
    q2.push_back(mk(1'b1, 28'h0ABC000, pat(32'h77000000), JUNK, 3, 0, 0, 0));
    wait_for(0, 20, t0, ok);
    #1 rst = 1'b0;
    #1;
    chk("s6_cmd_valid", mc_cmd_valid, 1'b0);
    chk("s6_grant", grant, 1'b0);
    chk("s6_error", error, 1'b0);
    chk("s6_mc_addr", mc_addr, '0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    q2.push_back(mk(1'b0, 28'h0001010, JUNK, pat(32'hC0DE0000), 0, 1, 0, 0));
    wait_for(2, 30, t1, ok);
    if (ok) begin
      chk("s6_rd2", mem_data_rd2,
          256'hC0DE0038_C0DE0030_C0DE0028_C0DE0020_C0DE0018_C0DE0010_C0DE0008_C0DE0000);
      chk("s6_grant_after", grant, 1'b1);
    end
    settle(50, nc, r1, r2);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
